// File: rtl/bcminer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcminer_pkg
//  Description : Shared widths, FSM state type and difficulty check for the
//                multi-lane block miner.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcminer_pkg;

  localparam int STATE_W = 352;
  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;
  localparam int DIFF_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } miner_state_t;

  // True when the top 'diff' bits of the hash are all zero (diff 0 always wins).
  function automatic logic meets_difficulty(input logic [HASH_W-1:0] hash,
                                            input logic [DIFF_W-1:0] diff);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < HASH_W; b++) begin
      if ((b < int'(diff)) && hash[HASH_W-1-b]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcm_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bcm_result_fifo
//  Description : Small circular FIFO for winning nonces. Pop is applied before
//                push, so a push into a full FIFO succeeds when a pop happens
//                in the same cycle. The head is held in its own register.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcm_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] w_count_after_pop;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic             w_pop;
  logic             w_push;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == C_DEPTH);
  assign head_o  = head_q;
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);

  // Next pointers, occupancy and the entry that will sit at the head next cycle.
  always_comb begin
    w_count_after_pop = count_q - {{(CNT_W-1){1'b0}}, w_pop};
    count_d           = w_count_after_pop + {{(CNT_W-1){1'b0}}, w_push};
    rd_ptr_d          = rd_ptr_q + {{(PTR_W-1){1'b0}}, w_pop};
    head_d            = mem_q[rd_ptr_d];
    if (w_push && (w_count_after_pop == '0)) head_d = push_data_i;
  end

  // Storage, pointers, count and head register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcminer_array.sv
`default_nettype none
// ============================================================================
//  Module      : bcminer_array
//  Description : Multi-lane miner top. Accepts a job, sweeps interleaved
//                nonces over NCORES hash lanes, waits out the core pipeline,
//                and queues winning nonces (lowest lane first) in a FIFO with
//                sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcminer_array
  import bcminer_pkg::*;
#(
  parameter int NCORES    = 4,
  parameter int COUNTBITS = 6,
  parameter int LATENCY   = 64,
  parameter int DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  input  logic [STATE_W-1:0]        blk_state,
  input  logic [DIFF_W-1:0]         blk_difficulty,
  output logic                      core_valid,
  output logic                      core_new,
  output logic [STATE_W-1:0]        core_state,
  output logic [NCORES*NONCE_W-1:0] core_nonce,
  input  logic [NCORES-1:0]         res_valid,
  input  logic [NCORES*HASH_W-1:0]  res_hash,
  input  logic [NCORES*NONCE_W-1:0] res_nonce,
  output logic                      nonce_valid,
  input  logic                      nonce_ready,
  output logic [NONCE_W-1:0]        nonce,
  output logic                      overflow,
  output logic                      busy,
  output logic                      sweep_done
);

  localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LATENCY - 1);

  // Nonce lanes must fit the sweep index plus lane index in 32 bits.
  if (COUNTBITS + $clog2(NCORES) > NONCE_W) begin : g_param_check
    $error("bcminer_array: COUNTBITS + log2(NCORES) exceeds nonce width");
  end

  miner_state_t          state_q;
  logic [COUNTBITS-1:0]  cnt_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [STATE_W-1:0]    job_state_q;
  logic [DIFF_W-1:0]     diff_q;
  logic                  sweep_done_q;
  logic                  overflow_q;
  logic                  overflow_d;

  logic [NCORES-1:0]     w_win;
  logic                  w_sel_valid;
  logic [NONCE_W-1:0]    w_sel_nonce;
  logic                  w_extra_win;
  logic                  w_accept;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_pop;
  logic                  w_drop;

  assign blk_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign core_valid  = (state_q == SWEEP);
  assign core_new    = core_valid && (cnt_q == '0);
  assign core_state  = job_state_q;
  assign sweep_done  = sweep_done_q;
  assign overflow    = overflow_q;
  assign nonce_valid = !w_fifo_empty;
  assign w_accept    = blk_ready && blk_valid;
  assign w_pop       = nonce_ready && !w_fifo_empty;

  // Per-lane nonce issue and difficulty check.
  for (genvar gi = 0; gi < NCORES; gi++) begin : g_lane
    assign core_nonce[gi*NONCE_W +: NONCE_W] =
        NONCE_W'(cnt_q) * NONCE_W'(NCORES) + NONCE_W'(gi);
    assign w_win[gi] = res_valid[gi] &&
        meets_difficulty(res_hash[gi*HASH_W +: HASH_W], diff_q);
  end

  // Pick the lowest winning lane; any further winner this cycle is lost.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_nonce = '0;
    w_extra_win = 1'b0;
    for (int i = 0; i < NCORES; i++) begin
      if (w_win[i]) begin
        if (w_sel_valid) begin
          w_extra_win = 1'b1;
        end else begin
          w_sel_valid = 1'b1;
          w_sel_nonce = res_nonce[i*NONCE_W +: NONCE_W];
        end
      end
    end
  end

  // Overflow: cleared by a new job, set by any lost winner in the same cycle.
  assign w_drop = w_sel_valid && w_fifo_full && !w_pop;
  always_comb begin
    overflow_d = w_accept ? 1'b0 : overflow_q;
    if (w_extra_win || w_drop) overflow_d = 1'b1;
  end

  // Sticky overflow register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else      overflow_q <= overflow_d;
  end

  // Job FSM: IDLE accepts, SWEEP issues 2^COUNTBITS steps, DRAIN waits LATENCY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wait_q       <= '0;
      job_state_q  <= '0;
      diff_q       <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      sweep_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (blk_valid) begin
            job_state_q <= blk_state;
            diff_q      <= blk_difficulty;
            cnt_q       <= '0;
            state_q     <= SWEEP;
          end
        end
        SWEEP: begin
          cnt_q <= cnt_q + COUNTBITS'(1);
          if (cnt_q == '1) begin
            wait_q  <= WAIT_INIT;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (wait_q == '0) begin
            state_q      <= IDLE;
            sweep_done_q <= 1'b1;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bcm_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NONCE_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_sel_valid),
    .push_data_i (w_sel_nonce),
    .pop_i       (nonce_ready),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .head_o      (nonce)
  );

endmodule
`default_nettype wire

// File: tb/tb_bcminer_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcminer_array
//  Description : Self-checking bench for bcminer_array with a cycle-count job
//                model and a queue-based result FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcminer_array;

  localparam int NC      = 4;
  localparam int CB      = 3;
  localparam int LAT     = 4;
  localparam int DP      = 4;
  localparam int JOB_CYC = (1 << CB) + LAT;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 blk_valid = 1'b0;
  logic                 blk_ready;
  logic [351:0]         blk_state = '0;
  logic [7:0]           blk_difficulty = '0;
  logic                 core_valid;
  logic                 core_new;
  logic [351:0]         core_state;
  logic [NC*32-1:0]     core_nonce;
  logic [NC-1:0]        res_valid = '0;
  logic [NC*256-1:0]    res_hash = '0;
  logic [NC*32-1:0]     res_nonce = '0;
  logic                 nonce_valid;
  logic                 nonce_ready = 1'b0;
  logic [31:0]          nonce;
  logic                 overflow;
  logic                 busy;
  logic                 sweep_done;

  always #5 clk = ~clk;

  bcminer_array #(
    .NCORES    (NC),
    .COUNTBITS (CB),
    .LATENCY   (LAT),
    .DEPTH     (DP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .blk_valid      (blk_valid),
    .blk_ready      (blk_ready),
    .blk_state      (blk_state),
    .blk_difficulty (blk_difficulty),
    .core_valid     (core_valid),
    .core_new       (core_new),
    .core_state     (core_state),
    .core_nonce     (core_nonce),
    .res_valid      (res_valid),
    .res_hash       (res_hash),
    .res_nonce      (res_nonce),
    .nonce_valid    (nonce_valid),
    .nonce_ready    (nonce_ready),
    .nonce          (nonce),
    .overflow       (overflow),
    .busy           (busy),
    .sweep_done     (sweep_done)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining job cycles, latched job data, result queue.
  int           m_busy = 0;
  bit           m_done = 1'b0;
  bit           m_ovf  = 1'b0;
  logic [7:0]   m_diff = '0;
  logic [351:0] m_state = '0;
  logic [31:0]  m_q[$];

  task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic int clz(input logic [255:0] h);
    int n = 0;
    while (n < 256 && h[255-n] == 1'b0) n++;
    return n;
  endfunction

  task automatic check_outputs();
    logic [NC*32-1:0] exp_nonce;
    int phase;
    phase = JOB_CYC - m_busy;
    chk("blk_ready",  352'(blk_ready),  352'(m_busy == 0));
    chk("busy",       352'(busy),       352'(m_busy != 0));
    chk("core_valid", 352'(core_valid), 352'(m_busy > LAT));
    chk("core_new",   352'(core_new),   352'(m_busy == JOB_CYC));
    chk("sweep_done", 352'(sweep_done), 352'(m_done));
    chk("overflow",   352'(overflow),   352'(m_ovf));
    chk("core_state", core_state,       m_state);
    chk("nonce_valid", 352'(nonce_valid), 352'(m_q.size() > 0));
    if (m_q.size() > 0) chk("nonce", 352'(nonce), 352'(m_q[0]));
    if (m_busy > LAT) begin
      for (int i = 0; i < NC; i++) exp_nonce[i*32 +: 32] = 32'(phase * NC + i);
      chk("core_nonce", 352'(core_nonce), 352'(exp_nonce));
    end
  endtask

  // One clock: evaluate the model on the inputs present before the edge.
  task automatic step();
    int          first;
    bit          multi;
    bit          pop;
    bit          accept;
    logic [31:0] win_nonce;
    first = -1;
    multi = 1'b0;
    win_nonce = '0;
    for (int i = 0; i < NC; i++) begin
      if (res_valid[i] && clz(res_hash[i*256 +: 256]) >= int'(m_diff)) begin
        if (first < 0) begin
          first = i;
          win_nonce = res_nonce[i*32 +: 32];
        end else begin
          multi = 1'b1;
        end
      end
    end
    pop    = (m_q.size() > 0) && nonce_ready;
    accept = (m_busy == 0) && blk_valid;
    @(posedge clk);
    #1;
    if (accept) m_ovf = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (first >= 0) begin
      if (m_q.size() < DP) m_q.push_back(win_nonce);
      else m_ovf = 1'b1;
    end
    if (multi) m_ovf = 1'b1;
    m_done = (m_busy == 1);
    if (m_busy > 0) m_busy--;
    if (accept) begin
      m_busy  = JOB_CYC;
      m_diff  = blk_difficulty;
      m_state = blk_state;
    end
    check_outputs();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    m_busy = 0; m_done = 1'b0; m_ovf = 1'b0; m_diff = '0; m_state = '0;
    m_q.delete();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [351:0] rand_state();
    logic [351:0] s;
    for (int w = 0; w < 11; w++) s[w*32 +: 32] = $urandom();
    return s;
  endfunction

  function automatic logic [255:0] rand_hash(input int max_shift);
    logic [255:0] h;
    for (int w = 0; w < 8; w++) h[w*32 +: 32] = $urandom();
    return h >> $urandom_range(0, max_shift);
  endfunction

  task automatic offer_job(input logic [7:0] diff);
    blk_valid      = 1'b1;
    blk_state      = rand_state();
    blk_difficulty = diff;
    step();
    blk_valid = 1'b0;
  endtask

  task automatic lane_win(input int lane, input logic [31:0] n);
    res_valid[lane] = 1'b1;
    res_hash[lane*256 +: 256] = {8'h00, rand_hash(0) >> 8} & {8'h00, {248{1'b1}}};
    res_nonce[lane*32 +: 32] = n;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 2 * JOB_CYC && m_busy != 0; k++) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cv_cnt;
    int sd_cnt;
    logic [31:0] got[$];
    logic [31:0] exp_order [5];
    exp_order = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd6};

    #2;
    apply_reset();

    // 1: reset while traffic is flowing
    offer_job(8'd2);
    for (int k = 0; k < 4; k++) begin
      res_valid = 4'($urandom());
      for (int i = 0; i < NC; i++) begin
        res_hash[i*256 +: 256] = rand_hash(6);
        res_nonce[i*32 +: 32]  = $urandom();
      end
      nonce_ready = 1'($urandom());
      step();
    end
    res_valid = '0;
    nonce_ready = 1'b0;
    apply_reset();
    chk("rst_blk_ready", 352'(blk_ready), 352'(1));
    chk("rst_nonce_valid", 352'(nonce_valid), 352'(0));

    // 2: single job timeline
    offer_job(8'd0);
    cv_cnt = int'(core_valid);
    sd_cnt = 0;
    for (int k = 0; k < JOB_CYC + 2; k++) begin
      step();
      cv_cnt += int'(core_valid);
      sd_cnt += int'(sweep_done);
    end
    chk("job_valid_cycles", 352'(cv_cnt), 352'(8));
    chk("job_done_pulses", 352'(sd_cnt), 352'(1));

    // 3: single winner on lane 1
    offer_job(8'd8);
    lane_win(1, 32'h25);
    step();
    res_valid = '0;
    chk("win_valid", 352'(nonce_valid), 352'(1));
    chk("win_nonce", 352'(nonce), 352'(32'h25));
    nonce_ready = 1'b1;
    step();
    nonce_ready = 1'b0;
    chk("win_popped", 352'(nonce_valid), 352'(0));

    // 4: simultaneous winners on lanes 0 and 3
    lane_win(0, 32'h10);
    lane_win(3, 32'h13);
    step();
    res_valid = '0;
    chk("multi_ovf", 352'(overflow), 352'(1));
    chk("multi_head", 352'(nonce), 352'(32'h10));
    nonce_ready = 1'b1;
    step();
    nonce_ready = 1'b0;
    wait_idle();
    chk("ovf_sticky", 352'(overflow), 352'(1));
    offer_job(8'd8);
    chk("ovf_cleared", 352'(overflow), 352'(0));

    // 5: FIFO full, then push with simultaneous pop
    for (int k = 1; k <= 5; k++) begin
      lane_win(0, 32'(k));
      step();
    end
    chk("full_ovf", 352'(overflow), 352'(1));
    chk("full_head", 352'(nonce), 352'(1));
    lane_win(0, 32'd6);
    nonce_ready = 1'b1;
    got.push_back(nonce);
    step();
    res_valid = '0;
    for (int k = 0; k < 8 && nonce_valid; k++) begin
      got.push_back(nonce);
      step();
    end
    nonce_ready = 1'b0;
    chk("drain_len", 352'(got.size()), 352'(5));
    for (int k = 0; k < 5 && k < got.size(); k++) chk("drain_order", 352'(got[k]), 352'(exp_order[k]));

    // 6: reset in the middle of a sweep, then restart from nonce 0
    wait_idle();
    lane_win(2, 32'h77);
    offer_job(8'd8);
    res_valid = '0;
    for (int k = 0; k < 3; k++) step();
    chk("mid_cnt3_lane0", 352'(core_nonce[31:0]), 352'(12));
    apply_reset();
    chk("mid_idle", 352'(busy), 352'(0));
    chk("mid_empty", 352'(nonce_valid), 352'(0));
    offer_job(8'd1);
    chk("restart_lane0", 352'(core_nonce[31:0]), 352'(0));
    chk("restart_new", 352'(core_new), 352'(1));

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      blk_valid = ($urandom_range(0, 3) == 0);
      blk_state = rand_state();
      case ($urandom_range(0, 9))
        8: blk_difficulty = 8'd255;
        9: blk_difficulty = 8'd8;
        default: blk_difficulty = 8'($urandom_range(0, 6));
      endcase
      res_valid = 4'($urandom());
      for (int i = 0; i < NC; i++) begin
        res_hash[i*256 +: 256] = rand_hash(12);
        res_nonce[i*32 +: 32]  = $urandom();
      end
      nonce_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
